dvi12_pixel_out: RTL

- Output stage between the VGA timing/pixel core and the 12-bit dual-PMOD HDMI module.
- Takes 24-bit RGB plus DE/HS/VS and produces 4-bit-per-channel color using 4x4 ordered (Bayer) dithering.
- Registers all outputs with equal latency so sync and data stay aligned at the pins.
- Forces black outside the active region and drives syncs at a programmable polarity.

---
 rtl/dvi12_pkg.sv | 20 ++
 rtl/dvi12_dither_chan.sv | 31 +++
 rtl/dvi12_pixel_out.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dvi12_pkg.sv
// Shared constants for the 12-bit DVI output stage: channel widths and the 4x4 Bayer threshold table.
package dvi12_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int THR_W = 4;

    // Indexed [y][x]; thresholds are compared against the 4 bits dropped by truncation.
    localparam logic [0:3][0:3][THR_W-1:0] BAYER_4X4 = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    function automatic logic [THR_W-1:0] bayer_thr(input logic [1:0] x, input logic [1:0] y);
        return BAYER_4X4[y][x];
    endfunction

endpackage

// File: rtl/dvi12_dither_chan.sv
// One colour channel quantizer: 8-bit in, 4-bit out, rounded up against a dither threshold, registered.
module dvi12_dither_chan
    import dvi12_pkg::*;
(
    input  logic             clk_40m_tree,
    input  logic             reset_loc,
    input  logic [IN_W-1:0]  c,
    input  logic [THR_W-1:0] t,
    input  logic             en,
    output logic [OUT_W-1:0] q
);

    logic [OUT_W-1:0] q_next;

    // Full-scale input stays at 15 rather than wrapping to 0.
    always_comb begin
        q_next = c[IN_W-1 -: OUT_W];
        if (en && (c[IN_W-OUT_W-1:0] > t) && (q_next != '1)) begin
            q_next = q_next + 1'b1;
        end
    end

    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/dvi12_pixel_out.sv
// Three-stage pixel output stage (input/count, quantize, blank/output) with matched sync delay.
// Build option DVI12_TEMPORAL_DITHER_EN rotates the Bayer pattern every frame.
module dvi12_pixel_out
    import dvi12_pkg::*;
#(
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
)
(
    input  logic        clk_40m_tree,
    input  logic        reset_loc,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [23:0] in_rgb,
    input  logic        dither_en,
    output logic [3:0]  out_r,
    output logic [3:0]  out_g,
    output logic [3:0]  out_b,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs
);

    logic        de1, hs1, vs1, en1;
    logic [23:0] rgb1;
    logic [1:0]  x_cnt, y_cnt, x1, y1;
    logic        vs_edge;
    logic [1:0]  x_idx, y_idx;
    logic [THR_W-1:0] thr;
    logic        de2, hs2, vs2;
    logic [OUT_W-1:0] q_r, q_g, q_b;

    // vs1 doubles as the previous-cycle vsync for edge detection.
    assign vs_edge = (in_vs == VS_POL) && (vs1 != VS_POL);

    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            de1   <= 1'b0;
            hs1   <= ~HS_POL;
            vs1   <= ~VS_POL;
            en1   <= 1'b0;
            rgb1  <= '0;
            x_cnt <= 2'd0;
            y_cnt <= 2'd0;
            x1    <= 2'd0;
            y1    <= 2'd0;
        end else begin
            de1  <= in_de;
            hs1  <= in_hs;
            vs1  <= in_vs;
            en1  <= dither_en;
            rgb1 <= in_rgb;
            x1   <= x_cnt;
            y1   <= y_cnt;
            x_cnt <= in_de ? x_cnt + 2'd1 : 2'd0;
            // Frame start overrides a line end landing on the same cycle.
            if (vs_edge) begin
                y_cnt <= 2'd0;
            end else if (de1 && !in_de) begin
                y_cnt <= y_cnt + 2'd1;
            end
        end
    end

`ifdef DVI12_TEMPORAL_DITHER_EN
    logic [1:0] frame_cnt;

    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            frame_cnt <= 2'd0;
        end else if (vs_edge) begin
            frame_cnt <= frame_cnt + 2'd1;
        end
    end

    assign x_idx = x1 + {frame_cnt[0], 1'b0};
    assign y_idx = y1 + {frame_cnt[1], 1'b0};
`else
    assign x_idx = x1;
    assign y_idx = y1;
`endif

    assign thr = bayer_thr(x_idx, y_idx);

    dvi12_dither_chan u_chan_r (
        .clk_40m_tree (clk_40m_tree),
        .reset_loc    (reset_loc),
        .c            (rgb1[23:16]),
        .t            (thr),
        .en           (en1),
        .q            (q_r)
    );

    dvi12_dither_chan u_chan_g (
        .clk_40m_tree (clk_40m_tree),
        .reset_loc    (reset_loc),
        .c            (rgb1[15:8]),
        .t            (thr),
        .en           (en1),
        .q            (q_g)
    );

    dvi12_dither_chan u_chan_b (
        .clk_40m_tree (clk_40m_tree),
        .reset_loc    (reset_loc),
        .c            (rgb1[7:0]),
        .t            (thr),
        .en           (en1),
        .q            (q_b)
    );

    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            de2 <= 1'b0;
            hs2 <= ~HS_POL;
            vs2 <= ~VS_POL;
        end else begin
            de2 <= de1;
            hs2 <= hs1;
            vs2 <= vs1;
        end
    end

    always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
        if (reset_loc) begin
            out_de <= 1'b0;
            out_hs <= ~HS_POL;
            out_vs <= ~VS_POL;
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
        end else begin
            out_de <= de2;
            out_hs <= hs2;
            out_vs <= vs2;
            out_r  <= de2 ? q_r : '0;
            out_g  <= de2 ? q_g : '0;
            out_b  <= de2 ? q_b : '0;
        end
    end

endmodule
